pipeline_stall_controller: RTL

- Central sequencer for the 5-stage ARM pipeline freeze/flush controls.
- Merges three stall/flush sources:
  - the hazard unit's hazard_detected;
  - the EXE-stage branch_taken;
  - multi-cycle SRAM accesses from the MEM stage.
- Drives a fixed-priority set of per-stage freeze and flush strobes.
- Tracks stall statistics and a sticky memory-timeout error.
- Sits beside the hazard detection unit; its outputs feed the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and the PC register.

---
 rtl/pipeline_stall_controller_pkg.sv | 13 +
 rtl/pipeline_stall_controller_sat_counter.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types for the pipeline stall controller: FSM state encoding.
package pipeline_stall_controller_pkg;

    localparam int STATE_W = 2;
    localparam int WAIT_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        STALL_RUN      = 2'd0,
        STALL_MEM_WAIT = 2'd1,
        STALL_ABORT    = 2'd2
    } stall_state_e;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall statistics; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Merges memory wait, branch flush and hazard stall into per-stage freeze/flush
// strobes with fixed priority, plus stall statistics and a sticky timeout flag.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard_detected,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 sram_ready,
    input  logic                 err_clear,
    output logic                 pc_freeze,
    output logic                 if_id_freeze,
    output logic                 if_id_flush,
    output logic                 id_exe_freeze,
    output logic                 id_exe_flush,
    output logic                 exe_mem_freeze,
    output logic                 mem_wb_bubble,
    output logic                 mem_busy,
    output logic                 mem_timeout_err,
    output logic [CNT_WIDTH-1:0] hazard_stall_cnt,
    output logic [CNT_WIDTH-1:0] mem_stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    stall_state_e      state_q;
    logic [WAIT_W-1:0] wait_q;
    logic              err_q;

    logic memstall;
    logic br_flush;
    logic hz_stall;
    logic timeout;

    // ABORT ignores mem_req so the faulting access retires instead of re-stalling.
    always_comb begin
        memstall = !rst && (((state_q == STALL_RUN) && mem_req && !sram_ready) ||
                            ((state_q == STALL_MEM_WAIT) && !sram_ready));
        br_flush = !rst && !memstall && branch_taken;
        hz_stall = !rst && !memstall && !branch_taken && hazard_detected;
        timeout  = (state_q == STALL_MEM_WAIT) && !sram_ready &&
                   (wait_q == WAIT_W'(MEM_TIMEOUT));
    end

    assign pc_freeze       = memstall | hz_stall;
    assign if_id_freeze    = memstall | hz_stall;
    assign if_id_flush     = br_flush;
    assign id_exe_freeze   = memstall;
    assign id_exe_flush    = br_flush | hz_stall;
    assign exe_mem_freeze  = memstall;
    assign mem_wb_bubble   = memstall;
    assign mem_busy        = !rst && (state_q == STALL_MEM_WAIT);
    assign mem_timeout_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STALL_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // A timeout in the same cycle as err_clear leaves the flag set.
            if (timeout) begin
                err_q <= 1'b1;
            end else if (err_clear) begin
                err_q <= 1'b0;
            end
            case (state_q)
                STALL_RUN: begin
                    if (mem_req && !sram_ready) begin
                        state_q <= STALL_MEM_WAIT;
                        wait_q  <= WAIT_W'(1);
                    end
                end
                STALL_MEM_WAIT: begin
                    if (sram_ready) begin
                        state_q <= STALL_RUN;
                    end else if (timeout) begin
                        state_q <= STALL_ABORT;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                STALL_ABORT: begin
                    state_q <= STALL_RUN;
                end
                default: begin
                    state_q <= STALL_RUN;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hazard_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hz_stall),
        .count (hazard_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mem_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (memstall),
        .count (mem_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_flush),
        .count (flush_cnt)
    );

endmodule
